rah_div_engine: RTL



---
 rtl/rah_div_pkg.sv | 29 ++
 rtl/rah_div_step.sv | 24 ++
 rtl/rah_div_engine.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rah_div_pkg.sv
// Shared types and packet layout for the RAH divider app stage.
package rah_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        PREP,
        DIV,
        FIX,
        WRITE
    } state_t;

    localparam int unsigned DEF_OP_WIDTH     = 24;
    localparam int unsigned DEF_PACKET_WIDTH = 2 * DEF_OP_WIDTH;

    // Request packet {dividend, divisor} and result packet {quotient, remainder}
    localparam int unsigned DIVIDEND_MSB = DEF_PACKET_WIDTH - 1;
    localparam int unsigned DIVIDEND_LSB = DEF_OP_WIDTH;
    localparam int unsigned DIVISOR_MSB  = DEF_OP_WIDTH - 1;
    localparam int unsigned DIVISOR_LSB  = 0;
    localparam int unsigned QUO_MSB      = DEF_PACKET_WIDTH - 1;
    localparam int unsigned QUO_LSB      = DEF_OP_WIDTH;
    localparam int unsigned REM_MSB      = DEF_OP_WIDTH - 1;
    localparam int unsigned REM_LSB      = 0;

    localparam logic [DEF_OP_WIDTH-1:0] DIV0_QUO = '1;

endpackage

// File: rtl/rah_div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left, trial-subtract, keep if non-negative.
module rah_div_step #(
    parameter int unsigned OP_WIDTH = 24
) (
    input  logic [OP_WIDTH:0]   rem_in,
    input  logic [OP_WIDTH-1:0] quo_in,
    input  logic [OP_WIDTH-1:0] divisor,
    output logic [OP_WIDTH:0]   rem_out,
    output logic [OP_WIDTH-1:0] quo_out
);

    logic [OP_WIDTH+1:0] shifted;
    logic [OP_WIDTH+1:0] trial;
    logic                trial_neg;

    always_comb begin
        shifted   = {rem_in, quo_in[OP_WIDTH-1]};
        trial     = shifted - {2'b00, divisor};
        trial_neg = trial[OP_WIDTH+1];
        rem_out   = trial_neg ? shifted[OP_WIDTH:0] : trial[OP_WIDTH:0];
        quo_out   = {quo_in[OP_WIDTH-2:0], ~trial_neg};
    end

endmodule

// File: rtl/rah_div_engine.sv
// Sequential divider between a RAH decoder queue and encoder: pop request, divide, push result.
module rah_div_engine
    import rah_div_pkg::*;
#(
    parameter int unsigned RAH_PACKET_WIDTH = DEF_PACKET_WIDTH,
    parameter int unsigned OP_WIDTH         = DEF_OP_WIDTH,
    parameter bit          SIGNED           = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [RAH_PACKET_WIDTH-1:0] rd_data,
    input  logic                        q_empty,
    output logic                        request_data,
    input  logic                        wr_full,
    output logic                        wr_en,
    output logic [RAH_PACKET_WIDTH-1:0] wr_data,
    output logic                        busy
);

    localparam int unsigned CNT_W   = $clog2(OP_WIDTH);
    localparam int unsigned DVD_LSB = OP_WIDTH;

    state_t              state;
    logic [OP_WIDTH-1:0] dvd;
    logic [OP_WIDTH-1:0] dvs;
    logic [OP_WIDTH-1:0] quo;
    logic [OP_WIDTH:0]   rem;
    logic [CNT_W-1:0]    cnt;
    logic                neg_q;
    logic                neg_r;

    logic [OP_WIDTH:0]   rem_nx;
    logic [OP_WIDTH-1:0] quo_nx;
    logic [OP_WIDTH-1:0] quo_fix;
    logic [OP_WIDTH-1:0] rem_fix;

    rah_div_step #(.OP_WIDTH(OP_WIDTH)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dvs),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    // Sign restoration of the magnitude result
    always_comb begin
        quo_fix = neg_q ? -quo : quo;
        rem_fix = neg_r ? -rem[OP_WIDTH-1:0] : rem[OP_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            request_data <= 1'b0;
            wr_en        <= 1'b0;
            wr_data      <= '0;
            busy         <= 1'b0;
            dvd          <= '0;
            dvs          <= '0;
            quo          <= '0;
            rem          <= '0;
            cnt          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!q_empty) begin
                        state        <= FETCH;
                        request_data <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                FETCH: begin
                    request_data <= 1'b0;
                    state        <= CAPTURE;
                end
                CAPTURE: begin
                    dvd   <= rd_data[RAH_PACKET_WIDTH-1:DVD_LSB];
                    dvs   <= rd_data[OP_WIDTH-1:0];
                    state <= PREP;
                end
                PREP: begin
                    if (SIGNED) begin
                        quo   <= dvd[OP_WIDTH-1] ? -dvd : dvd;
                        dvs   <= dvs[OP_WIDTH-1] ? -dvs : dvs;
                        neg_q <= dvd[OP_WIDTH-1] ^ dvs[OP_WIDTH-1];
                        neg_r <= dvd[OP_WIDTH-1];
                    end else begin
                        quo   <= dvd;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end
                    rem   <= '0;
                    cnt   <= CNT_W'(OP_WIDTH - 1);
                    state <= DIV;
                end
                DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    // A zero divisor has zero magnitude in both modes
                    if (dvs == '0) begin
                        wr_data <= {{OP_WIDTH{1'b1}}, dvd};
                    end else begin
                        wr_data <= {quo_fix, rem_fix};
                    end
                    wr_en <= !wr_full;
                    state <= WRITE;
                end
                WRITE: begin
                    // wr_en high here means the write strobe is in its single cycle
                    if (wr_en) begin
                        wr_en <= 1'b0;
                        if (!q_empty) begin
                            state        <= FETCH;
                            request_data <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (!wr_full) begin
                        wr_en <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    request_data <= 1'b0;
                    wr_en        <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
